// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (priority) and a host port.
// Optional DMEM_ARB_STATS_EN adds saturating stall/host-access counters (tied to 0 otherwise).
module dmem_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_we,
    input  logic             cpu_re,
    input  logic [WIDTH-1:0] cpu_a,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic [WIDTH-1:0] cpu_rd,
    output logic             cpu_stall,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [WIDTH-1:0] host_a,
    input  logic [WIDTH-1:0] host_wd,
    output logic             host_ack,
    output logic [WIDTH-1:0] host_rd,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      host_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, HOST, ACK} state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       cpu_req;
    logic       host_grant;

    assign cpu_req    = cpu_we | cpu_re;
    assign host_grant = (state == HOST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            host_rd  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (host_grant) begin
                host_rd <= host_we ? '0 : mem_rd;
            end
        end
    end

    // A host that abandons its request while waiting gets no ack; the forced grant
    // also leaves WAIT, so the counter never needs to exceed WAIT_LIMIT.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                wait_cnt_next = '0;
                if (host_req) begin
                    if (cpu_req) begin
                        state_next    = WAIT;
                        wait_cnt_next = 4'd1;
                    end else begin
                        state_next = HOST;
                    end
                end
            end
            WAIT: begin
                if (!host_req) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (!cpu_req || (wait_cnt >= WAIT_LIMIT)) begin
                    state_next    = HOST;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            HOST: begin
                state_next    = ACK;
                wait_cnt_next = '0;
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        mem_a     = host_grant ? host_a  : cpu_a;
        mem_wd    = host_grant ? host_wd : cpu_wd;
        mem_we    = !reset && (host_grant ? host_we : cpu_we);
        cpu_stall = !reset && host_grant && cpu_req;
        host_ack  = !reset && (state == ACK);
        cpu_rd    = mem_rd;
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] host_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            host_q  <= '0;
        end else begin
            if (cpu_stall && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (host_ack && (host_q != 16'hFFFF)) begin
                host_q <= host_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign host_cnt  = host_q;
`else
    assign stall_cnt = 16'h0;
    assign host_cnt  = 16'h0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-addressed memory model.
module tb_dmem_port_arbiter;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_we, cpu_re;
    logic [WIDTH-1:0] cpu_a, cpu_wd, cpu_rd;
    logic             cpu_stall;
    logic             host_req, host_we;
    logic [WIDTH-1:0] host_a, host_wd, host_rd;
    logic             host_ack;
    logic             mem_we;
    logic [WIDTH-1:0] mem_a, mem_wd, mem_rd;
    logic [15:0]      stall_cnt, host_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_a(host_a), .host_wd(host_wd),
        .host_ack(host_ack), .host_rd(host_rd),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .stall_cnt(stall_cnt), .host_cnt(host_cnt)
    );

    // Memory model: combinational read, write on clk; preload port shares the write process.
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [31:0] pre_a  = '0;
    logic [31:0] pre_d  = '0;
    int          write_count = 0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a[7:2]] <= pre_d;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
            write_count     <= write_count + 1;
        end
    end

    assign mem_rd = mem[mem_a[7:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_we = 0; cpu_re = 0; cpu_a = '0; cpu_wd = '0;
        host_req = 0; host_we = 0; host_a = '0; host_wd = '0;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pre_a = addr; pre_d = data; pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset  = 1'b1;
        cpu_we = 1'b1; cpu_a = 32'h3C; cpu_wd = 32'h99;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b expected 0", mem_we); end
        tick();
        tick();
        reset  = 1'b0;
        cpu_we = 1'b0;
        #1;
        checks++;
        if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_host_ack: got %0b expected 0", host_ack); end
        checks++;
        if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall: got %0b expected 0", cpu_stall); end
        checks++;
        if (host_rd !== 32'h0) begin errors++; $display("FAIL reset_host_rd: got %h expected 0", host_rd); end
        checks++;
        if (mem_a !== 32'h3C) begin errors++; $display("FAIL reset_cpu_owns: mem_a got %h expected 3c", mem_a); end
    endtask

    task automatic test_host_read();
        int ack_cycle = -1;
        logic stalled = 1'b0;
        logic [31:0] got_rd = '0;
        preload(32'h20, 32'hCAFE0001);
        host_req = 1; host_we = 0; host_a = 32'h20;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (cpu_stall) stalled = 1'b1;
            if (host_ack && ack_cycle < 0) begin
                ack_cycle = c;
                got_rd    = host_rd;
                host_req  = 0;
            end
            tick();
        end
        checks++;
        if (ack_cycle != 2) begin errors++; $display("FAIL host_read_latency: got %0d expected 2", ack_cycle); end
        checks++;
        if (got_rd !== 32'hCAFE0001) begin errors++; $display("FAIL host_read_data: got %h expected cafe0001", got_rd); end
        checks++;
        if (stalled !== 1'b0) begin errors++; $display("FAIL host_read_stall: got %0b expected 0", stalled); end
    endtask

    // Continuous CPU store stream that blocks a host write until the forced grant.
    task automatic test_forced_grant(input int n, input logic [31:0] base);
        int idx = 0;
        int stalls = 0;
        int ack_cycle = -1;
        int wc_start;
        logic stores_ok = 1'b1;
        wc_start = write_count;
        host_req = 1; host_we = 1; host_a = 32'h24; host_wd = 32'h55;
        for (int c = 0; c < 40 && (idx < n || ack_cycle < 0); c++) begin
            cpu_we = (idx < n);
            cpu_a  = base + 32'(4 * idx);
            cpu_wd = 32'h100 + 32'(idx);
            #1;
            if (cpu_stall) stalls++;
            if (host_ack && ack_cycle < 0) begin
                ack_cycle = c;
                host_req  = 0;
            end
            if (idx < n && !cpu_stall) idx++;
            tick();
        end
        cpu_we = 0; host_req = 0;
        tick();
        checks++;
        if (ack_cycle != MAX_WAIT + 2) begin errors++; $display("FAIL forced_latency: got %0d expected %0d", ack_cycle, MAX_WAIT + 2); end
        checks++;
        if (stalls != 1) begin errors++; $display("FAIL forced_stall_cycles: got %0d expected 1", stalls); end
        checks++;
        if (mem[6'h24 >> 2] !== 32'h55) begin errors++; $display("FAIL forced_host_write: got %h expected 55", mem[6'h24 >> 2]); end
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            if (mem[a[7:2]] !== 32'h100 + 32'(i)) stores_ok = 1'b0;
        end
        checks++;
        if (!stores_ok) begin errors++; $display("FAIL forced_store_stream: got incomplete expected all %0d stores", n); end
        checks++;
        if (write_count - wc_start != n + 1) begin errors++; $display("FAIL forced_write_count: got %0d expected %0d", write_count - wc_start, n + 1); end
    endtask

    task automatic test_cpu_during_host();
        preload(32'h10, 32'h1234ABCD);
        host_req = 1; host_we = 1; host_a = 32'h28; host_wd = 32'h77;
        tick();
        cpu_re = 1; cpu_a = 32'h10;
        #1;
        checks++;
        if (cpu_stall !== 1'b1) begin errors++; $display("FAIL cpu_host_stall: got %0b expected 1", cpu_stall); end
        checks++;
        if (mem_a !== 32'h28 || mem_we !== 1'b1) begin errors++; $display("FAIL cpu_host_owner: got a=%h we=%0b expected a=28 we=1", mem_a, mem_we); end
        tick();
        #1;
        checks++;
        if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_ack_stall: got %0b expected 0", cpu_stall); end
        checks++;
        if (host_ack !== 1'b1) begin errors++; $display("FAIL cpu_ack_pulse: got %0b expected 1", host_ack); end
        checks++;
        if (cpu_rd !== 32'h1234ABCD) begin errors++; $display("FAIL cpu_load_data: got %h expected 1234abcd", cpu_rd); end
        checks++;
        if (host_rd !== 32'h0) begin errors++; $display("FAIL host_write_rd: got %h expected 0", host_rd); end
        host_req = 0; cpu_re = 0;
        tick();
        #1;
        checks++;
        if (host_ack !== 1'b0) begin errors++; $display("FAIL cpu_ack_once: got %0b expected 0", host_ack); end
        checks++;
        if (mem[6'h28 >> 2] !== 32'h77) begin errors++; $display("FAIL cpu_host_write: got %h expected 77", mem[6'h28 >> 2]); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int last = 0;
        int min_gap = 100;
        logic [31:0] last_rd = '0;
        idle_inputs();
        host_req = 1; host_we = 0; host_a = 32'h20;
        for (int c = 0; c < 20 && acks < 3; c++) begin
            #1;
            if (host_ack) begin
                if (acks > 0 && (c - last) < min_gap) min_gap = c - last;
                acks++;
                last    = c;
                last_rd = host_rd;
                if (acks == 3) host_req = 0;
            end
            tick();
        end
        host_req = 0;
        tick();
        checks++;
        if (acks != 3) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 3", acks); end
        checks++;
        if (min_gap < 2) begin errors++; $display("FAIL b2b_min_gap: got %0d expected >=2", min_gap); end
        checks++;
        if (last_rd !== 32'hCAFE0001) begin errors++; $display("FAIL b2b_read_data: got %h expected cafe0001", last_rd); end
    endtask

    task automatic test_abandon();
        int acks = 0;
        int stalls = 0;
        idle_inputs();
        cpu_re = 1; cpu_a = 32'h10;
        host_req = 1; host_we = 1; host_a = 32'h2C; host_wd = 32'hBAD;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) host_req = 0;
            #1;
            if (host_ack) acks++;
            if (cpu_stall) stalls++;
            tick();
        end
        #1;
        checks++;
        if (acks != 0) begin errors++; $display("FAIL abandon_ack: got %0d expected 0", acks); end
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL abandon_stall: got %0d expected 0", stalls); end
        checks++;
        if (cpu_rd !== 32'h1234ABCD) begin errors++; $display("FAIL abandon_cpu_rd: got %h expected 1234abcd", cpu_rd); end
        cpu_re = 0;
        tick();
    endtask

    task automatic test_reset_in_host();
        preload(32'h30, 32'h0);
        host_req = 1; host_we = 1; host_a = 32'h30; host_wd = 32'hDEAD;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_host_mem_we: got %0b expected 0", mem_we); end
        host_req = 0; host_we = 0;
        tick();
        reset = 1'b0;
        cpu_re = 1; cpu_a = 32'h10;
        #1;
        checks++;
        if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_host_ack: got %0b expected 0", host_ack); end
        checks++;
        if (cpu_stall !== 1'b0 || mem_a !== 32'h10) begin errors++; $display("FAIL rst_host_idle: got stall=%0b a=%h expected stall=0 a=10", cpu_stall, mem_a); end
        checks++;
        if (mem[6'h30 >> 2] !== 32'h0) begin errors++; $display("FAIL rst_host_no_write: got %h expected 0", mem[6'h30 >> 2]); end
        tick();
        #1;
        checks++;
        if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_host_ack_late: got %0b expected 0", host_ack); end
        cpu_re = 0;
        tick();
    endtask

    task automatic test_stats();
        logic [15:0] exp_cnt;
`ifdef DMEM_ARB_STATS_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        do_reset();
        for (int r = 0; r < 3; r++) begin
            test_forced_grant(6, 32'h80);
        end
        #1;
        checks++;
        if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL stats_stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt); end
        checks++;
        if (host_cnt !== exp_cnt) begin errors++; $display("FAIL stats_host_cnt: got %0d expected %0d", host_cnt, exp_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_host_read();
        test_forced_grant(10, 32'h40);
        test_cpu_during_host();
        test_back_to_back();
        test_abandon();
        test_reset_in_host();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
